// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//   Two-port data memory arbiter. Two requesters (p0, p1) share a single
//   synchronous-write / combinational-read data memory. One access is
//   in flight at a time. Ties are broken round-robin. Each access is checked
//   for alignment, size and range, then formatted: byte lanes for stores,
//   shift plus extension for loads. Rejected accesses never reach the memory.
//   Each access completes with a one-cycle ack to the granted requester.
//
// Ports:
//   clk          in   1   clock, all state changes on the rising edge
//   reset        in   1   synchronous, active-low reset
//   pN_req_i     in   1   access request, held until ack
//   pN_addr_i    in   32  byte address
//   pN_wdata_i   in   32  right-aligned store data
//   pN_we_i      in   1   1 = store, 0 = load
//   pN_size_i    in   2   00 byte, 01 half, 10 word, 11 illegal
//   pN_uns_i     in   1   load zero-extend (1) / sign-extend (0)
//   pN_ack_o     out  1   one-cycle completion pulse
//   pN_err_o     out  1   access rejected (valid with ack)
//   pN_rdata_o   out  32  load result (valid with ack), 0 for stores
//   mem_addr_o   out  32  memory byte address
//   mem_wdata_o  out  32  lane-replicated store data
//   mem_we_o     out  4   per-byte write enables
//   mem_ce_o     out  1   memory chip enable
//   mem_rdata_i  in   32  memory read word, combinational from mem_addr_o
//   mem_valid_i  in   1   memory ready; an access commits on an edge where 1
// ----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        p0_req_i,
    input  logic [31:0] p0_addr_i,
    input  logic [31:0] p0_wdata_i,
    input  logic        p0_we_i,
    input  logic [1:0]  p0_size_i,
    input  logic        p0_uns_i,
    output logic        p0_ack_o,
    output logic        p0_err_o,
    output logic [31:0] p0_rdata_o,

    input  logic        p1_req_i,
    input  logic [31:0] p1_addr_i,
    input  logic [31:0] p1_wdata_i,
    input  logic        p1_we_i,
    input  logic [1:0]  p1_size_i,
    input  logic        p1_uns_i,
    output logic        p1_ack_o,
    output logic        p1_err_o,
    output logic [31:0] p1_rdata_o,

    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_we_o,
    output logic        mem_ce_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_valid_i
);

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_BYTES);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Formatting helpers
    // ------------------------------------------------------------------
    function automatic logic is_illegal(input logic [1:0]  size,
                                        input logic [31:0] addr);
        logic bad;
        bad = 1'b0;
        if (size == 2'b11)                          bad = 1'b1;
        if ((size == SZ_HALF) && addr[0])           bad = 1'b1;
        if ((size == SZ_WORD) && (addr[1:0] != 2'b00)) bad = 1'b1;
        if (addr >= ADDR_LIMIT)                     bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size,
                                           input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << off;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicating the store data across lanes lets the byte enables alone
    // pick the destination lane, so no store-side shifter is needed.
    function automatic logic [31:0] store_data(input logic [1:0]  size,
                                               input logic [31:0] wdata);
        logic [31:0] sd;
        case (size)
            SZ_BYTE: sd = {4{wdata[7:0]}};
            SZ_HALF: sd = {2{wdata[15:0]}};
            default: sd = wdata;
        endcase
        return sd;
    endfunction

    function automatic logic [31:0] load_fmt(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input logic [1:0]  size,
                                             input logic        uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_BYTE: res = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}},  sh[7:0]};
            SZ_HALF: res = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;  // 0 = p0, 1 = p1
    logic        grant_q, grant_d;            // port owning the current access
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    // ------------------------------------------------------------------
    // Arbitration: p1 wins only when it is alone, or on a tie when p0 was
    // the last port served.
    // ------------------------------------------------------------------
    logic        any_req;
    logic        sel_p1;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_we;
    logic [1:0]  sel_size;
    logic        sel_uns;

    always_comb begin
        any_req   = p0_req_i | p1_req_i;
        sel_p1    = p1_req_i & (~p0_req_i | ~last_grant_q);
        sel_addr  = sel_p1 ? p1_addr_i  : p0_addr_i;
        sel_wdata = sel_p1 ? p1_wdata_i : p0_wdata_i;
        sel_we    = sel_p1 ? p1_we_i    : p0_we_i;
        sel_size  = sel_p1 ? p1_size_i  : p0_size_i;
        sel_uns   = sel_p1 ? p1_uns_i   : p0_uns_i;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        err_d        = err_q;
        rdata_d      = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant_d      = sel_p1;
                    last_grant_d = sel_p1;
                    addr_d       = sel_addr;
                    wdata_d      = sel_wdata;
                    we_d         = sel_we;
                    size_d       = sel_size;
                    uns_d        = sel_uns;
                    rdata_d      = 32'h0;
                    err_d        = is_illegal(sel_size, sel_addr);
                    // Rejected accesses skip the memory entirely.
                    state_d      = is_illegal(sel_size, sel_addr) ? S_RESP : S_ACCESS;
                end
            end

            S_ACCESS: begin
                if (mem_valid_i) begin
                    rdata_d = we_q ? 32'h0
                                   : load_fmt(mem_rdata_i, addr_q[1:0], size_q, uns_q);
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;   // makes p0 win the first tie
            grant_q      <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. All outputs are gated by reset so that asserting reset
    // mid-access immediately suppresses the memory write and the ack.
    // ------------------------------------------------------------------
    logic in_access;
    logic in_resp;

    always_comb begin
        in_access = reset & (state_q == S_ACCESS);
        in_resp   = reset & (state_q == S_RESP);

        mem_ce_o    = in_access & mem_valid_i;
        mem_addr_o  = in_access ? addr_q : 32'h0;
        mem_wdata_o = (in_access & we_q) ? store_data(size_q, wdata_q) : 32'h0;
        mem_we_o    = (in_access & we_q & mem_valid_i) ? byte_en(size_q, addr_q[1:0])
                                                       : 4'b0000;

        p0_ack_o   = in_resp & ~grant_q;
        p0_err_o   = in_resp & ~grant_q & err_q;
        p0_rdata_o = (in_resp & ~grant_q) ? rdata_q : 32'h0;

        p1_ack_o   = in_resp & grant_q;
        p1_err_o   = in_resp & grant_q & err_q;
        p1_rdata_o = (in_resp & grant_q) ? rdata_q : 32'h0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed testbench for dmem_arbiter. A small word-organised memory model
// answers reads combinationally from mem_addr_o and applies byte-lane writes
// on clock edges where mem_ce_o is high. It also records chip-enable activity
// so the bench can count accesses. Inputs are driven 1 ns after the rising
// edge and outputs are sampled 2 ns after it.
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic        p0_req_i, p0_we_i, p0_uns_i;
    logic [31:0] p0_addr_i, p0_wdata_i;
    logic [1:0]  p0_size_i;
    logic        p0_ack_o, p0_err_o;
    logic [31:0] p0_rdata_o;

    logic        p1_req_i, p1_we_i, p1_uns_i;
    logic [31:0] p1_addr_i, p1_wdata_i;
    logic [1:0]  p1_size_i;
    logic        p1_ack_o, p1_err_o;
    logic [31:0] p1_rdata_o;

    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_we_o;
    logic        mem_ce_o, mem_valid_i;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_BYTES(128)) dut (
        .clk         (clk),
        .reset       (reset),
        .p0_req_i    (p0_req_i),
        .p0_addr_i   (p0_addr_i),
        .p0_wdata_i  (p0_wdata_i),
        .p0_we_i     (p0_we_i),
        .p0_size_i   (p0_size_i),
        .p0_uns_i    (p0_uns_i),
        .p0_ack_o    (p0_ack_o),
        .p0_err_o    (p0_err_o),
        .p0_rdata_o  (p0_rdata_o),
        .p1_req_i    (p1_req_i),
        .p1_addr_i   (p1_addr_i),
        .p1_wdata_i  (p1_wdata_i),
        .p1_we_i     (p1_we_i),
        .p1_size_i   (p1_size_i),
        .p1_uns_i    (p1_uns_i),
        .p1_ack_o    (p1_ack_o),
        .p1_err_o    (p1_err_o),
        .p1_rdata_o  (p1_rdata_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_we_o    (mem_we_o),
        .mem_ce_o    (mem_ce_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_valid_i (mem_valid_i)
    );

    // ---------------- memory model ----------------
    logic [31:0] memw [0:31];
    logic        pl_en;
    logic [4:0]  pl_idx;
    logic [31:0] pl_word;
    int          ce_cnt = 0;
    int          wr_cnt = 0;
    logic [3:0]  last_we = 4'h0;
    logic [31:0] last_wdata = 32'h0;

    always_comb mem_rdata_i = memw[mem_addr_o[6:2]];

    always @(posedge clk) begin
        if (pl_en) begin
            memw[pl_idx] <= pl_word;
        end else if (mem_ce_o && (mem_we_o != 4'h0)) begin
            for (int i = 0; i < 4; i++)
                if (mem_we_o[i]) memw[mem_addr_o[6:2]][8*i +: 8] <= mem_wdata_o[8*i +: 8];
        end
        if (mem_ce_o) begin
            ce_cnt     <= ce_cnt + 1;
            last_we    <= mem_we_o;
            last_wdata <= mem_wdata_o;
            if (mem_we_o != 4'h0) wr_cnt <= wr_cnt + 1;
        end
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] word);
        pl_idx  = addr[6:2];
        pl_word = word;
        pl_en   = 1'b1;
        cyc();
        pl_en   = 1'b0;
        #1;
    endtask

    task automatic set_req(input bit port, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic we, input logic [1:0] size, input logic uns);
        if (port) begin
            p1_addr_i = addr; p1_wdata_i = wdata; p1_we_i = we;
            p1_size_i = size; p1_uns_i = uns;   p1_req_i = 1'b1;
        end else begin
            p0_addr_i = addr; p0_wdata_i = wdata; p0_we_i = we;
            p0_size_i = size; p0_uns_i = uns;   p0_req_i = 1'b1;
        end
    endtask

    // Counts cycles from the request cycle (0) to the ack cycle; -1 on timeout.
    // Legal accesses ack in cycle 2 (3 cycles inclusive), rejected ones in cycle 1.
    task automatic wait_ack(input bit port, input int max, output int lat);
        lat = 0;
        while (((port ? p1_ack_o : p0_ack_o) !== 1'b1) && (lat < max)) begin
            cyc();
            #1;
            lat++;
        end
        if ((port ? p1_ack_o : p0_ack_o) !== 1'b1) lat = -1;
    endtask

    // Requester sees its ack and drops req in the following cycle.
    task automatic release_reqs();
        cyc();
        p0_req_i = 1'b0;
        p1_req_i = 1'b0;
        #1;
    endtask

    // Rejection table: addr, size, expected err, expected latency
    logic [31:0] tb_addr [0:4];
    logic [1:0]  tb_size [0:4];
    logic        tb_err  [0:4];
    int          tb_lat  [0:4];

    int lat;
    int c0;
    int w0;

    initial begin
        tb_addr[0] = 32'd1;   tb_size[0] = 2'b01; tb_err[0] = 1'b1; tb_lat[0] = 1;
        tb_addr[1] = 32'd0;   tb_size[1] = 2'b11; tb_err[1] = 1'b1; tb_lat[1] = 1;
        tb_addr[2] = 32'd2;   tb_size[2] = 2'b10; tb_err[2] = 1'b1; tb_lat[2] = 1;
        tb_addr[3] = 32'd128; tb_size[3] = 2'b00; tb_err[3] = 1'b1; tb_lat[3] = 1;
        tb_addr[4] = 32'd127; tb_size[4] = 2'b00; tb_err[4] = 1'b0; tb_lat[4] = 2;

        reset = 1'b0; mem_valid_i = 1'b1; pl_en = 1'b0; pl_idx = 5'd0; pl_word = 32'h0;
        p0_req_i = 0; p0_addr_i = 0; p0_wdata_i = 0; p0_we_i = 0; p0_size_i = 0; p0_uns_i = 0;
        p1_req_i = 0; p1_addr_i = 0; p1_wdata_i = 0; p1_we_i = 0; p1_size_i = 0; p1_uns_i = 0;

        preload(32'd0,   32'h11112222);
        preload(32'd4,   32'h33334444);
        preload(32'd12,  32'h5555AAAA);
        preload(32'd124, 32'h7F000000);

        // Held in reset with a request pending: nothing may happen.
        set_req(0, 32'd0, 32'h0, 1'b0, 2'b10, 1'b0);
        cyc(); #1;
        chk("rst_ce",  32'(mem_ce_o), 32'd0);
        chk("rst_we",  32'(mem_we_o), 32'd0);
        chk("rst_ack", 32'(p0_ack_o), 32'd0);
        cyc(); #1;
        chk("rst_ce2", 32'(mem_ce_o), 32'd0);

        // Tie out of reset: p0 first, then p1.
        cyc();
        reset = 1'b1;
        set_req(1, 32'd4, 32'h0, 1'b0, 2'b10, 1'b0);
        c0 = ce_cnt;
        #1;
        wait_ack(0, 8, lat);
        chk("tie_p0_lat",   32'(lat), 32'd2);
        chk("tie_p0_rdata", p0_rdata_o, 32'h11112222);
        chk("tie_p0_err",   32'(p0_err_o), 32'd0);
        chk("tie_p1_noack", 32'(p1_ack_o), 32'd0);
        chk("tie_p1_rdata0", p1_rdata_o, 32'h0);
        cyc();
        p0_req_i = 1'b0;
        #1;
        wait_ack(1, 8, lat);
        chk("tie_p1_lat",   32'(lat), 32'd2);
        chk("tie_p1_rdata", p1_rdata_o, 32'h33334444);
        chk("tie_p0_noack", 32'(p0_ack_o), 32'd0);
        chk("tie_ce_count", 32'(ce_cnt - c0), 32'd2);
        release_reqs();

        // Byte store 0xA5 at addr 6.
        c0 = ce_cnt;
        set_req(0, 32'd6, 32'h000000A5, 1'b1, 2'b00, 1'b0);
        #1;
        wait_ack(0, 8, lat);
        chk("sb_lat",      32'(lat), 32'd2);
        chk("sb_ce_count", 32'(ce_cnt - c0), 32'd1);
        chk("sb_we",       32'(last_we), 32'h4);
        chk("sb_wdata",    last_wdata, 32'hA5A5A5A5);
        chk("sb_rdata",    p0_rdata_o, 32'h0);
        chk("sb_err",      32'(p0_err_o), 32'd0);
        release_reqs();
        set_req(1, 32'd4, 32'h0, 1'b0, 2'b10, 1'b0);
        #1;
        wait_ack(1, 8, lat);
        chk("sb_readback", p1_rdata_o, 32'h33A54444);
        release_reqs();

        // Load formatting on word 0x80FF1234.
        preload(32'd0, 32'h80FF1234);
        set_req(0, 32'd3, 32'h0, 1'b0, 2'b00, 1'b0);
        #1;
        wait_ack(0, 8, lat);
        chk("lb_signed", p0_rdata_o, 32'hFFFFFF80);
        release_reqs();
        set_req(0, 32'd1, 32'h0, 1'b0, 2'b00, 1'b1);
        #1;
        wait_ack(0, 8, lat);
        chk("lbu", p0_rdata_o, 32'h00000012);
        release_reqs();
        set_req(1, 32'd2, 32'h0, 1'b0, 2'b01, 1'b0);
        #1;
        wait_ack(1, 8, lat);
        chk("lh_signed", p1_rdata_o, 32'hFFFF80FF);
        release_reqs();
        set_req(1, 32'd2, 32'h0, 1'b0, 2'b01, 1'b1);
        #1;
        wait_ack(1, 8, lat);
        chk("lhu",      p1_rdata_o, 32'h000080FF);
        chk("lhu_lat",  32'(lat), 32'd2);
        release_reqs();

        // Two rejected accesses at once: misaligned word and out-of-range byte.
        c0 = ce_cnt;
        set_req(0, 32'd5,   32'h0, 1'b0, 2'b10, 1'b0);
        set_req(1, 32'd200, 32'h0, 1'b0, 2'b00, 1'b0);
        #1;
        wait_ack(0, 6, lat);
        chk("rej_p0_lat", 32'(lat), 32'd1);
        chk("rej_p0_err", 32'(p0_err_o), 32'd1);
        chk("rej_p1_noerr", 32'(p1_err_o), 32'd0);
        cyc();
        p0_req_i = 1'b0;
        #1;
        wait_ack(1, 6, lat);
        chk("rej_p1_lat", 32'(lat), 32'd1);
        chk("rej_p1_err", 32'(p1_err_o), 32'd1);
        chk("rej_no_ce",  32'(ce_cnt - c0), 32'd0);
        release_reqs();

        for (int k = 0; k < 5; k++) begin
            set_req(0, tb_addr[k], 32'h0, 1'b0, tb_size[k], 1'b1);
            #1;
            wait_ack(0, 6, lat);
            chk($sformatf("tbl%0d_err", k), 32'(p0_err_o), 32'(tb_err[k]));
            chk($sformatf("tbl%0d_lat", k), 32'(lat), 32'(tb_lat[k]));
            release_reqs();
        end

        // Reset while a store waits in ACCESS.
        w0 = wr_cnt;
        mem_valid_i = 1'b0;
        set_req(0, 32'd12, 32'hDEADBEEF, 1'b1, 2'b10, 1'b0);
        cyc(); #1;
        chk("ab_access_addr", mem_addr_o, 32'd12);
        chk("ab_access_ce",   32'(mem_ce_o), 32'd0);
        reset = 1'b0;
        mem_valid_i = 1'b1;
        #1;
        chk("ab_rst_ce",  32'(mem_ce_o), 32'd0);
        chk("ab_rst_we",  32'(mem_we_o), 32'd0);
        chk("ab_rst_ack", 32'(p0_ack_o), 32'd0);
        cyc();
        p0_req_i = 1'b0;
        #1;
        chk("ab_rst_ack2", 32'(p0_ack_o), 32'd0);
        cyc();
        reset = 1'b1;
        #1;
        chk("ab_no_write", 32'(wr_cnt - w0), 32'd0);
        chk("ab_no_ack",   32'(p0_ack_o), 32'd0);
        set_req(0, 32'd0,  32'h0, 1'b0, 2'b10, 1'b0);
        set_req(1, 32'd12, 32'h0, 1'b0, 2'b10, 1'b0);
        #1;
        wait_ack(0, 8, lat);
        chk("ab_tie_p0_lat",   32'(lat), 32'd2);
        chk("ab_tie_p0_rdata", p0_rdata_o, 32'h80FF1234);
        chk("ab_tie_p1_noack", 32'(p1_ack_o), 32'd0);
        cyc();
        p0_req_i = 1'b0;
        #1;
        wait_ack(1, 8, lat);
        chk("ab_mem_intact", p1_rdata_o, 32'h5555AAAA);
        release_reqs();

        // Memory stalls for 10 cycles.
        mem_valid_i = 1'b0;
        set_req(0, 32'd4, 32'h0, 1'b0, 2'b10, 1'b0);
        cyc(); #1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stall%0d_ce", i),  32'(mem_ce_o), 32'd0);
            chk($sformatf("stall%0d_ack", i), 32'(p0_ack_o), 32'd0);
            cyc(); #1;
        end
        chk("stall_addr", mem_addr_o, 32'd4);
        mem_valid_i = 1'b1;
        #1;
        chk("stall_ce_rise", 32'(mem_ce_o), 32'd1);
        cyc(); #1;
        chk("stall_ack",   32'(p0_ack_o), 32'd1);
        chk("stall_rdata", p0_rdata_o, 32'h33A54444);
        release_reqs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
